// File: rtl/arbiter_pkg.sv
// Shared types and the rotating-priority helper for the burst round-robin arbiter.
package arbiter_pkg;

  // Arbiter FSM: IDLE picks a new winner, LOCKED holds the channel for a burst.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Widest requester vector the helper handles; callers cast down to N.
  localparam int ARB_MAX_N = 32;
  localparam int ARB_IDX_W = 5;

  // Return a one-hot grant for the first set bit of req, scanning ptr, ptr+1, ...
  // and wrapping at n by explicit compare so non-power-of-two n works.
  function automatic logic [ARB_MAX_N-1:0] rr_select(
    input logic [ARB_MAX_N-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [ARB_MAX_N-1:0] grant;
    logic                 found;
    int unsigned          idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < ARB_MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[ARB_IDX_W'(idx)]) begin
          grant[ARB_IDX_W'(idx)] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority picker: one-hot grant plus its index.
module rr_priority_select
  import arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  // Pick the first requester at or after ptr and encode its index.
  always_comb begin
    grant    = N'(rr_select(ARB_MAX_N'(req), 32'(ptr), N));
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

endmodule

// File: rtl/arbiter_rr_burst.sv
// Burst-granular round-robin arbiter with a registered output stage.
// Handshake: a beat moves on a port in any cycle where valid and ready are both
// high; a requester holds valid/data stable until accepted, and ready never
// depends on that port's own data.
// Optional macro ARBITER_RR_BURST_MAXLEN_EN bounds bursts to MAX_BEATS beats and
// adds the `overrun` pulse output.
module arbiter_rr_burst
  import arbiter_pkg::*;
#(
  parameter int DWIDTH            = 16,
  parameter int N                 = 2,
  parameter int INIT_HIGHEST_PRIO = 0
`ifdef ARBITER_RR_BURST_MAXLEN_EN
  , parameter int MAX_BEATS       = 16
`endif
  , localparam int IDW            = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  input  logic              in_last  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output arb_state_t        dbg_state
`ifdef ARBITER_RR_BURST_MAXLEN_EN
  , output logic            overrun
`endif
);

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    lock_id_q, lock_id_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic [N-1:0]      req, sel_grant, grant;
  logic [IDW-1:0]    sel_id, win_id;
  logic              can_load, accept, win_last, beat_last;

  // Flatten the request valids for the picker.
  always_comb begin
    for (int i = 0; i < N; i++) req[i] = in_valid[i];
  end

  rr_priority_select #(.N(N)) u_sel (
    .req      (req),
    .ptr      (ptr_q),
    .grant    (sel_grant),
    .grant_id (sel_id)
  );

  // Grant source (picker in IDLE, locked owner otherwise) and the input handshake.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    grant    = sel_grant;
    win_id   = sel_id;
    if (state_q == ARB_LOCKED) begin
      grant            = '0;
      grant[lock_id_q] = 1'b1;
      win_id           = lock_id_q;
    end
    for (int i = 0; i < N; i++) in_ready[i] = can_load & grant[i] & ~rst;
    accept   = can_load & ~rst & (|(grant & req));
    win_last = in_last[win_id];
  end

`ifdef ARBITER_RR_BURST_MAXLEN_EN
  localparam int CNTW = $clog2(MAX_BEATS + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            overrun_q, overrun_d;
  logic            force_last;

  // Count beats in the current burst and force a close at MAX_BEATS.
  always_comb begin
    force_last = (cnt_q == CNTW'(MAX_BEATS - 1));
    beat_last  = win_last | force_last;
    cnt_d      = cnt_q;
    overrun_d  = 1'b0;
    if (accept) begin
      cnt_d     = beat_last ? '0 : cnt_q + CNTW'(1);
      overrun_d = force_last & ~win_last;
    end
  end
`else
  assign beat_last = win_last;
`endif

  // FSM, priority rotation and output register next-state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[win_id];
      out_last_d  = beat_last;
      out_id_d    = win_id;
      if (beat_last) begin
        state_d = ARB_IDLE;
        ptr_d   = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = win_id;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IDW'(INIT_HIGHEST_PRIO);
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
`ifdef ARBITER_RR_BURST_MAXLEN_EN
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
`ifdef ARBITER_RR_BURST_MAXLEN_EN
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign dbg_state = state_q;
`ifdef ARBITER_RR_BURST_MAXLEN_EN
  assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Testbench for arbiter_rr_burst (N=4): directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_arbiter_rr_burst;
  import arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IDW = 2;
`ifdef ARBITER_RR_BURST_MAXLEN_EN
  localparam int MAXB = 4;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid [N-1:0];
  logic [DW-1:0]  in_data  [N-1:0];
  logic           in_last  [N-1:0];
  logic           in_ready [N-1:0];
  logic           out_valid, out_last, out_ready;
  logic [DW-1:0]  out_data;
  logic [IDW-1:0] out_id;
  arb_state_t     dbg_state;
`ifdef ARBITER_RR_BURST_MAXLEN_EN
  logic           overrun;
`endif

  logic [N-1:0] rdy_vec;
  always_comb begin
    for (int i = 0; i < N; i++) rdy_vec[i] = in_ready[i];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  arbiter_rr_burst #(
    .DWIDTH(DW), .N(N), .INIT_HIGHEST_PRIO(0)
`ifdef ARBITER_RR_BURST_MAXLEN_EN
    , .MAX_BEATS(MAXB)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .dbg_state(dbg_state)
`ifdef ARBITER_RR_BURST_MAXLEN_EN
    , .overrun(overrun)
`endif
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_none();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      in_last[i]  = 1'b0;
      in_data[i]  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive_none();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got_o;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1;
      in_last[i]  = 1'b1;
      in_data[i]  = 16'h5A5A;
    end
    tick();
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== 20'h0) begin
      n_err++; $display("FAIL reset_out: got %h expected %h", got_o, 20'h0);
    end
    n_vec++;
    if (rdy_vec !== 4'b0000) begin
      n_err++; $display("FAIL reset_rdy: got %b expected %b", rdy_vec, 4'b0000);
    end
    n_vec++;
    if (dbg_state !== ARB_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARB_IDLE);
    end
  endtask

  task automatic test_reset_priority();
    logic [19:0] got_o, exp_o;
    logic [N-1:0] exp_r;
    do_reset();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1;
      in_last[i]  = 1'b1;
      in_data[i]  = 16'(16'hA000 + i);
    end
    settle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL prio_latency: got %b expected 0", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      exp_r = 4'(1 << (k % 4));
      n_vec++;
      if (rdy_vec !== exp_r) begin
        n_err++; $display("FAIL prio_rdy k%0d: got %b expected %b", k, rdy_vec, exp_r);
      end
      tick();
      got_o = {out_valid, out_last, out_id, out_data};
      exp_o = {1'b1, 1'b1, 2'(k % 4), 16'(16'hA000 + k % 4)};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL prio_out k%0d: got %h expected %h", k, got_o, exp_o);
      end
    end
    drive_none();
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL prio_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_burst_lock();
    logic [19:0] got_o, exp_o;
    do_reset();
    in_valid[1] = 1'b1; in_last[1] = 1'b1; in_data[1] = 16'h1B00;
    for (int c = 0; c < 3; c++) begin
      in_valid[0] = 1'b1; in_data[0] = 16'(16'h0B00 + c); in_last[0] = (c == 2);
      settle();
      n_vec++;
      if (rdy_vec !== 4'b0001) begin
        n_err++; $display("FAIL lock_rdy c%0d: got %b expected %b", c, rdy_vec, 4'b0001);
      end
      tick();
      got_o = {out_valid, out_last, out_id, out_data};
      exp_o = {1'b1, (c == 2), 2'd0, 16'(16'h0B00 + c)};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL lock_beat c%0d: got %h expected %h", c, got_o, exp_o);
      end
      if (c == 0) begin
        n_vec++;
        if (dbg_state !== ARB_LOCKED) begin
          n_err++; $display("FAIL lock_state: got %0d expected %0d", dbg_state, ARB_LOCKED);
        end
      end
    end
    in_valid[0] = 1'b0;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0010) begin
      n_err++; $display("FAIL lock_next_rdy: got %b expected %b", rdy_vec, 4'b0010);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== {1'b1, 1'b1, 2'd1, 16'h1B00}) begin
      n_err++; $display("FAIL lock_next_out: got %h expected %h", got_o, {1'b1, 1'b1, 2'd1, 16'h1B00});
    end
  endtask

  task automatic test_bubble();
    logic [19:0] got_o, exp_o;
    do_reset();
    in_valid[2] = 1'b1; in_last[2] = 1'b1; in_data[2] = 16'h2C00;
    for (int b = 0; b < 3; b++) begin
      in_valid[0] = 1'b1; in_data[0] = 16'(16'h0C00 + b); in_last[0] = (b == 2);
      settle();
      n_vec++;
      if (rdy_vec !== 4'b0001) begin
        n_err++; $display("FAIL bubble_rdy b%0d: got %b expected %b", b, rdy_vec, 4'b0001);
      end
      tick();
      got_o = {out_valid, out_last, out_id, out_data};
      exp_o = {1'b1, (b == 2), 2'd0, 16'(16'h0C00 + b)};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL bubble_beat b%0d: got %h expected %h", b, got_o, exp_o);
      end
      if (b == 0) begin
        for (int g = 0; g < 2; g++) begin
          in_valid[0] = 1'b0;
          settle();
          n_vec++;
          if (rdy_vec !== 4'b0001) begin
            n_err++; $display("FAIL bubble_hold g%0d: got %b expected %b", g, rdy_vec, 4'b0001);
          end
          tick();
          n_vec++;
          if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bubble_gap g%0d: got %b expected 0", g, out_valid);
          end
        end
      end
    end
    in_valid[0] = 1'b0;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0100) begin
      n_err++; $display("FAIL bubble_next_rdy: got %b expected %b", rdy_vec, 4'b0100);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== {1'b1, 1'b1, 2'd2, 16'h2C00}) begin
      n_err++; $display("FAIL bubble_next_out: got %h expected %h", got_o, {1'b1, 1'b1, 2'd2, 16'h2C00});
    end
  endtask

  task automatic test_backpressure();
    int sent[N];
    logic acc[N];
    int c, xfer, j;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      for (int s = 0; s < 3; s++) exp_q.push_back({2'(i), 14'(14'h100 + s)});
    end
    c = 0;
    xfer = 0;
    while (xfer < 12 && c < 40) begin
      out_ready = !(c >= 1 && c <= 5);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = (sent[i] < 3);
        in_data[i]  = {2'(i), 14'(14'h100 + sent[i])};
        in_last[i]  = 1'b1;
      end
      settle();
      if (c >= 1 && c <= 5) begin
        n_vec++;
        if (rdy_vec !== 4'b0000) begin
          n_err++; $display("FAIL bp_rdy c%0d: got %b expected %b", c, rdy_vec, 4'b0000);
        end
        n_vec++;
        if ({out_valid, out_data} !== {1'b1, 16'h0100}) begin
          n_err++; $display("FAIL bp_hold c%0d: got %h expected %h", c, {out_valid, out_data}, {1'b1, 16'h0100});
        end
      end
      if (c >= 6) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL bp_throughput c%0d: got %b expected 1", c, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        j = -1;
        for (int q = 0; q < exp_q.size(); q++) begin
          if (j < 0 && exp_q[q][DW-1:DW-2] == out_id) j = q;
        end
        n_vec++;
        if (j < 0) begin
          n_err++; $display("FAIL bp_sb_unexpected: got %h expected none left for id %0d", out_data, out_id);
        end else begin
          if (exp_q[j] !== out_data) begin
            n_err++; $display("FAIL bp_sb_order: got %h expected %h", out_data, exp_q[j]);
          end
          exp_q.delete(j);
        end
        xfer++;
      end
      for (int i = 0; i < N; i++) acc[i] = in_valid[i] & in_ready[i];
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
      c++;
    end
    n_vec++;
    if (xfer != 12 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_complete: got %0d beats, %0d left expected 12 beats, 0 left", xfer, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] got_o;
    do_reset();
    in_valid[1] = 1'b1; in_last[1] = 1'b0; in_data[1] = 16'h1D00;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0010) begin
      n_err++; $display("FAIL rmid_rdy0: got %b expected %b", rdy_vec, 4'b0010);
    end
    tick();
    in_data[1] = 16'h1D01;
    rst = 1'b1;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0000) begin
      n_err++; $display("FAIL rmid_rdy_rst: got %b expected %b", rdy_vec, 4'b0000);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== 20'h0) begin
      n_err++; $display("FAIL rmid_out: got %h expected %h", got_o, 20'h0);
    end
    n_vec++;
    if (dbg_state !== ARB_IDLE) begin
      n_err++; $display("FAIL rmid_state: got %0d expected %0d", dbg_state, ARB_IDLE);
    end
    rst = 1'b0;
    in_valid[0] = 1'b1; in_last[0] = 1'b1; in_data[0] = 16'h0D00;
    in_data[1] = 16'h1D00; in_last[1] = 1'b1;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0001) begin
      n_err++; $display("FAIL rmid_prio_rdy: got %b expected %b", rdy_vec, 4'b0001);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== {1'b1, 1'b1, 2'd0, 16'h0D00}) begin
      n_err++; $display("FAIL rmid_prio_out: got %h expected %h", got_o, {1'b1, 1'b1, 2'd0, 16'h0D00});
    end
  endtask

`ifdef ARBITER_RR_BURST_MAXLEN_EN
  task automatic test_overrun();
    logic [19:0] got_o, exp_o;
    do_reset();
    in_valid[3] = 1'b1; in_last[3] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_data[3] = 16'(16'h3E00 + b);
      settle();
      n_vec++;
      if (rdy_vec !== 4'b1000) begin
        n_err++; $display("FAIL ovr_rdy b%0d: got %b expected %b", b, rdy_vec, 4'b1000);
      end
      tick();
      got_o = {out_valid, out_last, out_id, out_data};
      exp_o = {1'b1, (b == 3), 2'd3, 16'(16'h3E00 + b)};
      n_vec++;
      if (got_o !== exp_o || overrun !== (b == 3)) begin
        n_err++; $display("FAIL ovr_beat b%0d: got %h/%b expected %h/%b", b, got_o, overrun, exp_o, (b == 3));
      end
    end
    in_data[3] = 16'h3E04;
    in_valid[0] = 1'b1; in_last[0] = 1'b1; in_data[0] = 16'h0E00;
    settle();
    n_vec++;
    if (rdy_vec !== 4'b0001) begin
      n_err++; $display("FAIL ovr_other_rdy: got %b expected %b", rdy_vec, 4'b0001);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== {1'b1, 1'b1, 2'd0, 16'h0E00} || overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_other_out: got %h/%b expected %h/0", got_o, overrun, {1'b1, 1'b1, 2'd0, 16'h0E00});
    end
    settle();
    n_vec++;
    if (rdy_vec !== 4'b1000) begin
      n_err++; $display("FAIL ovr_back_rdy: got %b expected %b", rdy_vec, 4'b1000);
    end
    tick();
    got_o = {out_valid, out_last, out_id, out_data};
    n_vec++;
    if (got_o !== {1'b1, 1'b0, 2'd3, 16'h3E04}) begin
      n_err++; $display("FAIL ovr_back_out: got %h expected %h", got_o, {1'b1, 1'b0, 2'd3, 16'h3E04});
    end
  endtask
`endif

  // Randomized traffic against a reference model built from the arbitration rules:
  // owner = requester holding the channel (-1 when free), ptr = first index scanned.
  task automatic test_random();
    int m_ptr, m_owner, m_cnt, g, w, cyc;
    logic m_ov, m_ol, m_ovr, m_can, lst, drain, go, done;
    logic [DW-1:0] m_od;
    logic [IDW-1:0] m_oid;
    logic [N-1:0] exp_r;
    logic hold[N];
    int left[N];
    logic [DW-1:0] dat[N];
    do_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_oid = '0; m_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 1'b0; left[i] = 0; dat[i] = '0;
    end
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 700) begin
      drain = (cyc >= 400);
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          if (left[i] > 0) go = drain || ($urandom_range(0, 2) != 0);
          else             go = !drain && ($urandom_range(0, 2) == 0);
          if (go) begin
            if (left[i] == 0) left[i] = $urandom_range(1, 6);
            hold[i] = 1'b1;
            dat[i]  = 16'($urandom);
          end
        end
        in_valid[i] = hold[i];
        in_data[i]  = dat[i];
        in_last[i]  = (left[i] == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      m_can = !m_ov || out_ready;
      g = -1;
      if (m_owner >= 0) g = m_owner;
      else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_r = (m_can && g >= 0) ? 4'(1 << g) : 4'b0000;
      w = (m_can && g >= 0 && in_valid[g]) ? g : -1;
      n_vec++;
      if (rdy_vec !== exp_r) begin
        n_err++; $display("FAIL rand_rdy cyc%0d: got %b expected %b", cyc, rdy_vec, exp_r);
      end
      tick();
      m_ovr = 1'b0;
      if (w >= 0) begin
        lst = in_last[w];
`ifdef ARBITER_RR_BURST_MAXLEN_EN
        if (m_cnt == MAXB - 1) begin
          m_ovr = !lst;
          lst   = 1'b1;
        end
`endif
        m_ov = 1'b1; m_od = in_data[w]; m_ol = lst; m_oid = IDW'(w);
        if (lst) begin
          m_owner = -1; m_ptr = (w + 1) % N; m_cnt = 0;
        end else begin
          m_owner = w; m_cnt++;
        end
        hold[w] = 1'b0;
        left[w]--;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      n_vec++;
      if ({out_valid, out_last, out_id, out_data} !== {m_ov, m_ol, m_oid, m_od}) begin
        n_err++; $display("FAIL rand_out cyc%0d: got %h expected %h", cyc, {out_valid, out_last, out_id, out_data}, {m_ov, m_ol, m_oid, m_od});
      end
      n_vec++;
      if (dbg_state !== ((m_owner >= 0) ? ARB_LOCKED : ARB_IDLE)) begin
        n_err++; $display("FAIL rand_state cyc%0d: got %0d expected owner %0d", cyc, dbg_state, m_owner);
      end
`ifdef ARBITER_RR_BURST_MAXLEN_EN
      n_vec++;
      if (overrun !== m_ovr) begin
        n_err++; $display("FAIL rand_overrun cyc%0d: got %b expected %b", cyc, overrun, m_ovr);
      end
`endif
      done = drain && !m_ov;
      for (int i = 0; i < N; i++) if (hold[i] || left[i] != 0) done = 1'b0;
      cyc++;
    end
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL rand_drain_timeout: got not drained after %0d cycles expected drained", cyc);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    out_ready = 1'b1;
    drive_none();
    test_reset();
    test_reset_priority();
    test_burst_lock();
    test_bubble();
    test_backpressure();
    test_reset_mid();
`ifdef ARBITER_RR_BURST_MAXLEN_EN
    test_overrun();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
